axi_lite_mem_arbiter: RTL and testbench

Two-master AXI-Lite arbiter that shares the single memory slave port between the instruction fetch unit (read-only master) and the load/store unit (read and write master). It sits between the core's IFU/LSU master ports and the memory/SRAM AXI-Lite slave. It serialises exactly one outstanding transaction at a time, from address handshake to response handshake. Reads are granted round-robin; an LSU write pre-empts any pending read decision.

---
 rtl/axi_lite_mem_arbiter_if.sv | 26 ++
 rtl/axi_lite_mem_arbiter.sv | 79 +++++++
 tb/tb_axi_lite_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem_arbiter_if.sv
// axi_lite_mem_arbiter_if: one AXI-Lite port bundle (AR/R/AW/W/B); master drives requests, slave drives responses.
interface axi_lite_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid, r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_valid, w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid, b_ready;
  logic [1:0]        b_resp;
  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: shares one AXI-Lite memory slave between IFU (read-only) and LSU, one transaction at a time.
module axi_lite_mem_arbiter (
  input  logic clk_i,
  input  logic rst_i,
  axi_lite_mem_arbiter_if.slave  ifu,
  axi_lite_mem_arbiter_if.slave  lsu,
  axi_lite_mem_arbiter_if.master slv
);
  typedef enum logic [3:0] {
    IDLE       = 4'b0001,
    GNT_IFU_RD = 4'b0010,
    GNT_LSU_RD = 4'b0100,
    GNT_LSU_WR = 4'b1000
  } state_t;
  state_t state_q, state_d;
  logic last_rd_q, last_rd_d;
  logic ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd_ifu, rd_lsu, wr, b_en, pick_ifu, r_hs, b_hs, unused;
  assign rd_ifu = state_q == GNT_IFU_RD;
  assign rd_lsu = state_q == GNT_LSU_RD;
  assign wr     = state_q == GNT_LSU_WR;
  assign b_en   = wr & aw_done_q & w_done_q;
  // ar_done masks the address channel so a master still holding ar_valid is not accepted twice
  assign slv.ar_valid = ((rd_ifu & ifu.ar_valid) | (rd_lsu & lsu.ar_valid)) & ~ar_done_q;
  assign slv.ar_addr  = rd_lsu ? lsu.ar_addr : ifu.ar_addr;
  assign ifu.ar_ready = rd_ifu & ~ar_done_q & slv.ar_ready;
  assign lsu.ar_ready = rd_lsu & ~ar_done_q & slv.ar_ready;
  assign slv.r_ready  = (rd_ifu & ifu.r_ready) | (rd_lsu & lsu.r_ready);
  assign ifu.r_valid  = rd_ifu & slv.r_valid;
  assign lsu.r_valid  = rd_lsu & slv.r_valid;
  assign ifu.r_data   = slv.r_data;
  assign lsu.r_data   = slv.r_data;
  assign ifu.r_resp   = slv.r_resp;
  assign lsu.r_resp   = slv.r_resp;
  assign slv.aw_valid = wr & ~aw_done_q & lsu.aw_valid;
  assign slv.aw_addr  = lsu.aw_addr;
  assign lsu.aw_ready = wr & ~aw_done_q & slv.aw_ready;
  assign slv.w_valid  = wr & ~w_done_q & lsu.w_valid;
  assign slv.w_data   = lsu.w_data;
  assign slv.w_strb   = lsu.w_strb;
  assign lsu.w_ready  = wr & ~w_done_q & slv.w_ready;
  assign slv.b_ready  = b_en & lsu.b_ready;
  assign lsu.b_valid  = b_en & slv.b_valid;
  assign lsu.b_resp   = slv.b_resp;
  assign ifu.b_resp   = slv.b_resp;
  assign ifu.aw_ready = 1'b0;
  assign ifu.w_ready  = 1'b0;
  assign ifu.b_valid  = 1'b0;
  assign unused = ^{ifu.aw_valid, ifu.aw_addr, ifu.w_valid, ifu.w_data, ifu.w_strb, ifu.b_ready};
  assign r_hs = slv.r_valid & slv.r_ready;
  assign b_hs = slv.b_valid & slv.b_ready;
  // last_rd_q high means the LSU had the last read, so the IFU wins the next tie
  assign pick_ifu = ifu.ar_valid & (~lsu.ar_valid | last_rd_q);
  always_comb begin
    state_d   = (state_q == IDLE) ? ((lsu.aw_valid & lsu.w_valid) ? GNT_LSU_WR :
                                     pick_ifu ? GNT_IFU_RD :
                                     lsu.ar_valid ? GNT_LSU_RD : IDLE)
                                  : ((r_hs | b_hs) ? IDLE : state_q);
    last_rd_d = (state_d == GNT_IFU_RD) ? 1'b0 : (state_d == GNT_LSU_RD) ? 1'b1 : last_rd_q;
    ar_done_d = (state_d == IDLE) ? 1'b0 : ar_done_q | (slv.ar_valid & slv.ar_ready);
    aw_done_d = (state_d == IDLE) ? 1'b0 : aw_done_q | (slv.aw_valid & slv.aw_ready);
    w_done_d  = (state_d == IDLE) ? 1'b0 : w_done_q | (slv.w_valid & slv.w_ready);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb_axi_lite_mem_arbiter: scenario tasks plus a scoreboard of expected slave-side requests and master-side responses.
module tb_axi_lite_mem_arbiter;
  logic clk, rst_i;
  int checks, errors;
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [34:0] exp_r[$];
  logic [1:0]  exp_b[$];

  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu();
  axi_lite_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) slv();

  axi_lite_mem_arbiter dut (.clk_i(clk), .rst_i(rst_i), .ifu(ifu), .lsu(lsu), .slv(slv));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Every handshake seen on the DUT is matched against the oldest expectation of its channel.
  task automatic monitor;
    logic [31:0] ea;
    logic [35:0] ew;
    logic [34:0] er;
    logic [1:0]  eb;
    if (!rst_i) begin
      if (slv.ar_valid && slv.ar_ready) begin
        checks++;
        ea = exp_ar.size() ? exp_ar.pop_front() : 'x;
        if (slv.ar_addr !== ea) begin errors++; $display("FAIL sb_ar: got %h expected %h", slv.ar_addr, ea); end
      end
      if (slv.aw_valid && slv.aw_ready) begin
        checks++;
        ea = exp_aw.size() ? exp_aw.pop_front() : 'x;
        if (slv.aw_addr !== ea) begin errors++; $display("FAIL sb_aw: got %h expected %h", slv.aw_addr, ea); end
      end
      if (slv.w_valid && slv.w_ready) begin
        checks++;
        ew = exp_w.size() ? exp_w.pop_front() : 'x;
        if ({slv.w_data, slv.w_strb} !== ew) begin errors++; $display("FAIL sb_w: got %h expected %h", {slv.w_data, slv.w_strb}, ew); end
      end
      if (ifu.r_valid && ifu.r_ready) begin
        checks++;
        er = exp_r.size() ? exp_r.pop_front() : 'x;
        if ({1'b0, ifu.r_data, ifu.r_resp} !== er) begin errors++; $display("FAIL sb_r_ifu: got %h expected %h", {1'b0, ifu.r_data, ifu.r_resp}, er); end
      end
      if (lsu.r_valid && lsu.r_ready) begin
        checks++;
        er = exp_r.size() ? exp_r.pop_front() : 'x;
        if ({1'b1, lsu.r_data, lsu.r_resp} !== er) begin errors++; $display("FAIL sb_r_lsu: got %h expected %h", {1'b1, lsu.r_data, lsu.r_resp}, er); end
      end
      if (lsu.b_valid && lsu.b_ready) begin
        checks++;
        eb = exp_b.size() ? exp_b.pop_front() : 'x;
        if (lsu.b_resp !== eb) begin errors++; $display("FAIL sb_b: got %h expected %h", lsu.b_resp, eb); end
      end
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ifu.ar_valid = 0; ifu.ar_addr = 0; ifu.r_ready = 0; ifu.aw_valid = 0; ifu.aw_addr = 0;
    ifu.w_valid = 0; ifu.w_data = 0; ifu.w_strb = 0; ifu.b_ready = 0;
    lsu.ar_valid = 0; lsu.ar_addr = 0; lsu.r_ready = 0; lsu.aw_valid = 0; lsu.aw_addr = 0;
    lsu.w_valid = 0; lsu.w_data = 0; lsu.w_strb = 0; lsu.b_ready = 0;
    slv.ar_ready = 0; slv.r_valid = 0; slv.r_data = 0; slv.r_resp = 0; slv.aw_ready = 0;
    slv.w_ready = 0; slv.b_valid = 0; slv.b_resp = 0;
  endtask

  task automatic apply_reset;
    rst_i = 1;
    idle_inputs();
    cyc();
    rst_i = 0;
  endtask

  task automatic test_reset;
    logic [11:0] outs;
    rst_i = 1;
    idle_inputs();
    cyc();
    ifu.ar_valid = 1; lsu.ar_valid = 1; lsu.aw_valid = 1; lsu.w_valid = 1;
    ifu.r_ready = 1; lsu.r_ready = 1; lsu.b_ready = 1;
    slv.ar_ready = 1; slv.aw_ready = 1; slv.w_ready = 1; slv.r_valid = 1; slv.b_valid = 1;
    #2;
    outs = {slv.ar_valid, slv.aw_valid, slv.w_valid, slv.r_ready, slv.b_ready, ifu.ar_ready,
            ifu.r_valid, lsu.ar_ready, lsu.aw_ready, lsu.w_ready, lsu.r_valid, lsu.b_valid};
    checks++;
    if (outs !== 12'h000) begin errors++; $display("FAIL reset_outs: got %h expected %h", outs, 12'h000); end
    cyc();
    idle_inputs();
    rst_i = 0;
    slv.r_valid = 1; slv.b_valid = 1; ifu.r_ready = 1; lsu.r_ready = 1; lsu.b_ready = 1;
    #2;
    checks++;
    if ({slv.r_ready, slv.b_ready, ifu.r_valid, lsu.r_valid, lsu.b_valid} !== 5'b0)
      begin errors++; $display("FAIL idle_resp_blocked: got %b expected %b", {slv.r_ready, slv.b_ready, ifu.r_valid, lsu.r_valid, lsu.b_valid}, 5'b0); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_ifu_read;
    ifu.ar_valid = 1; ifu.ar_addr = 32'h8000_0000; ifu.r_ready = 1; slv.ar_ready = 1;
    exp_ar.push_back(32'h8000_0000);
    #2;
    checks++;
    if (slv.ar_valid !== 1'b0) begin errors++; $display("FAIL ifu_rd_ar_early: got %b expected %b", slv.ar_valid, 1'b0); end
    cyc();
    #2;
    checks++;
    if ({slv.ar_valid, ifu.ar_ready} !== 2'b11) begin errors++; $display("FAIL ifu_rd_ar_grant: got %b expected %b", {slv.ar_valid, ifu.ar_ready}, 2'b11); end
    cyc();
    #2;
    checks++;
    if ({slv.ar_valid, ifu.ar_ready} !== 2'b00) begin errors++; $display("FAIL ifu_rd_ar_masked: got %b expected %b", {slv.ar_valid, ifu.ar_ready}, 2'b00); end
    cyc();
    ifu.ar_valid = 0; slv.ar_ready = 0;
    slv.r_valid = 1; slv.r_data = 32'h0000_0413; slv.r_resp = 2'b00;
    exp_r.push_back({1'b0, 32'h0000_0413, 2'b00});
    #2;
    checks++;
    if ({ifu.r_valid, lsu.r_valid, slv.r_ready} !== 3'b101) begin errors++; $display("FAIL ifu_rd_r_route: got %b expected %b", {ifu.r_valid, lsu.r_valid, slv.r_ready}, 3'b101); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_round_robin;
    int done, pend, arh;
    int ar_at[$];
    int r_at[$];
    apply_reset();
    ifu.ar_valid = 1; ifu.ar_addr = 32'h8000_0000; lsu.ar_valid = 1; lsu.ar_addr = 32'h8000_1000;
    ifu.r_ready = 1; lsu.r_ready = 1; slv.ar_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_ar.push_back(k[0] ? 32'h8000_1000 : 32'h8000_0000);
      exp_r.push_back({k[0], 32'h100 + k, 2'b00});
    end
    done = 0; pend = 0;
    for (int c = 0; c < 40 && done < 4; c++) begin
      slv.r_valid = pend[0]; slv.r_data = 32'h100 + done; slv.r_resp = 2'b00;
      #2;
      arh = (slv.ar_valid && slv.ar_ready) ? 1 : 0;
      if (arh != 0) ar_at.push_back(c);
      if (slv.r_valid && slv.r_ready) begin r_at.push_back(c); done++; pend = 0; end
      cyc();
      if (arh != 0) pend = 1;
    end
    idle_inputs();
    checks++;
    if (done != 4) begin errors++; $display("FAIL rr_count: got %0d expected %0d", done, 4); end
    if (done == 4 && ar_at.size() == 4) begin
      checks++;
      if (ar_at[0] != 1) begin errors++; $display("FAIL rr_first_latency: got %0d expected %0d", ar_at[0], 1); end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ar_at[k+1] - r_at[k] != 2) begin errors++; $display("FAIL rr_gap_%0d: got %0d expected %0d", k, ar_at[k+1] - r_at[k], 2); end
      end
    end
  endtask

  task automatic test_write_w_first;
    lsu.aw_valid = 1; lsu.aw_addr = 32'h8000_2000; lsu.w_valid = 1; lsu.w_data = 32'hDEAD_BEEF;
    lsu.w_strb = 4'hF; lsu.b_ready = 1;
    exp_aw.push_back(32'h8000_2000);
    exp_w.push_back({32'hDEAD_BEEF, 4'hF});
    exp_b.push_back(2'b00);
    #2;
    checks++;
    if ({slv.aw_valid, slv.w_valid} !== 2'b00) begin errors++; $display("FAIL wr_early: got %b expected %b", {slv.aw_valid, slv.w_valid}, 2'b00); end
    cyc();
    slv.w_ready = 1;
    #2;
    checks++;
    if ({slv.aw_valid, slv.w_valid, lsu.aw_ready, lsu.w_ready} !== 4'b1101) begin errors++; $display("FAIL wr_c1: got %b expected %b", {slv.aw_valid, slv.w_valid, lsu.aw_ready, lsu.w_ready}, 4'b1101); end
    cyc();
    slv.b_valid = 1; slv.b_resp = 2'b00;
    #2;
    checks++;
    if ({slv.w_valid, lsu.w_ready, lsu.b_valid, slv.b_ready} !== 4'b0000) begin errors++; $display("FAIL wr_c2_wmask: got %b expected %b", {slv.w_valid, lsu.w_ready, lsu.b_valid, slv.b_ready}, 4'b0000); end
    cyc();
    slv.aw_ready = 1;
    #2;
    checks++;
    if ({slv.aw_valid, lsu.aw_ready, lsu.b_valid} !== 3'b110) begin errors++; $display("FAIL wr_c3_aw: got %b expected %b", {slv.aw_valid, lsu.aw_ready, lsu.b_valid}, 3'b110); end
    cyc();
    lsu.aw_valid = 0; lsu.w_valid = 0; slv.aw_ready = 0; slv.w_ready = 0;
    #2;
    checks++;
    if ({lsu.b_valid, slv.b_ready} !== 2'b11) begin errors++; $display("FAIL wr_c4_b: got %b expected %b", {lsu.b_valid, slv.b_ready}, 2'b11); end
    cyc();
    #2;
    checks++;
    if ({lsu.b_valid, slv.b_ready} !== 2'b00) begin errors++; $display("FAIL wr_idle: got %b expected %b", {lsu.b_valid, slv.b_ready}, 2'b00); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_write_preempts_read;
    ifu.ar_valid = 1; ifu.ar_addr = 32'h8000_0040; ifu.r_ready = 1;
    lsu.aw_valid = 1; lsu.aw_addr = 32'h8000_3000; lsu.w_valid = 1; lsu.w_data = 32'h1234_5678;
    lsu.w_strb = 4'h3; lsu.b_ready = 1;
    slv.ar_ready = 1; slv.aw_ready = 1; slv.w_ready = 1;
    exp_aw.push_back(32'h8000_3000);
    exp_w.push_back({32'h1234_5678, 4'h3});
    exp_b.push_back(2'b01);
    exp_ar.push_back(32'h8000_0040);
    exp_r.push_back({1'b0, 32'hCAFE_0001, 2'b00});
    cyc();
    #2;
    checks++;
    if ({slv.aw_valid, slv.w_valid, slv.ar_valid, ifu.ar_ready} !== 4'b1100) begin errors++; $display("FAIL pre_wr_first: got %b expected %b", {slv.aw_valid, slv.w_valid, slv.ar_valid, ifu.ar_ready}, 4'b1100); end
    cyc();
    lsu.aw_valid = 0; lsu.w_valid = 0; slv.b_valid = 1; slv.b_resp = 2'b01;
    #2;
    checks++;
    if (lsu.b_valid !== 1'b1) begin errors++; $display("FAIL pre_b: got %b expected %b", lsu.b_valid, 1'b1); end
    cyc();
    slv.b_valid = 0;
    #2;
    checks++;
    if (slv.ar_valid !== 1'b0) begin errors++; $display("FAIL pre_idle_gap: got %b expected %b", slv.ar_valid, 1'b0); end
    cyc();
    #2;
    checks++;
    if ({slv.ar_valid, ifu.ar_ready} !== 2'b11) begin errors++; $display("FAIL pre_rd_grant: got %b expected %b", {slv.ar_valid, ifu.ar_ready}, 2'b11); end
    cyc();
    ifu.ar_valid = 0; slv.ar_ready = 0; slv.r_valid = 1; slv.r_data = 32'hCAFE_0001; slv.r_resp = 2'b00;
    #2;
    checks++;
    if (ifu.r_valid !== 1'b1) begin errors++; $display("FAIL pre_rd_r: got %b expected %b", ifu.r_valid, 1'b1); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read;
    logic [11:0] outs;
    ifu.ar_valid = 1; ifu.ar_addr = 32'h8000_0080; ifu.r_ready = 1; slv.ar_ready = 1;
    exp_ar.push_back(32'h8000_0080);
    cyc();
    cyc();
    ifu.ar_valid = 0; slv.ar_ready = 0;
    #1;
    rst_i = 1;
    slv.r_valid = 1; slv.r_data = 32'h0000_DEAD; lsu.aw_valid = 1; lsu.w_valid = 1;
    slv.aw_ready = 1; slv.w_ready = 1; slv.b_valid = 1; lsu.b_ready = 1;
    #1;
    outs = {slv.ar_valid, slv.aw_valid, slv.w_valid, slv.r_ready, slv.b_ready, ifu.ar_ready,
            ifu.r_valid, lsu.ar_ready, lsu.aw_ready, lsu.w_ready, lsu.r_valid, lsu.b_valid};
    checks++;
    if (outs !== 12'h000) begin errors++; $display("FAIL midrst_outs: got %h expected %h", outs, 12'h000); end
    cyc();
    idle_inputs();
    rst_i = 0;
    ifu.ar_valid = 1; ifu.ar_addr = 32'h8000_00C0; ifu.r_ready = 1; slv.ar_ready = 1;
    exp_ar.push_back(32'h8000_00C0);
    cyc();
    #2;
    checks++;
    if (slv.ar_valid !== 1'b1) begin errors++; $display("FAIL midrst_regrant: got %b expected %b", slv.ar_valid, 1'b1); end
    cyc();
    ifu.ar_valid = 0; slv.ar_ready = 0; slv.r_valid = 1; slv.r_data = 32'h0000_5555; slv.r_resp = 2'b00;
    exp_r.push_back({1'b0, 32'h0000_5555, 2'b00});
    #2;
    checks++;
    if (ifu.r_valid !== 1'b1) begin errors++; $display("FAIL midrst_r: got %b expected %b", ifu.r_valid, 1'b1); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_error_passthrough;
    lsu.ar_valid = 1; lsu.ar_addr = 32'h8000_0100; lsu.r_ready = 1; ifu.r_ready = 1; slv.ar_ready = 1;
    exp_ar.push_back(32'h8000_0100);
    cyc();
    #2;
    checks++;
    if ({lsu.ar_ready, ifu.ar_ready} !== 2'b10) begin errors++; $display("FAIL err_grant: got %b expected %b", {lsu.ar_ready, ifu.ar_ready}, 2'b10); end
    cyc();
    lsu.ar_valid = 0; slv.ar_ready = 0; slv.r_valid = 1; slv.r_data = 32'h0000_BAD0; slv.r_resp = 2'b10;
    exp_r.push_back({1'b1, 32'h0000_BAD0, 2'b10});
    #2;
    checks++;
    if ({lsu.r_valid, ifu.r_valid, lsu.r_resp, ifu.r_resp} !== 6'b10_10_10) begin errors++; $display("FAIL err_resp: got %b expected %b", {lsu.r_valid, ifu.r_valid, lsu.r_resp, ifu.r_resp}, 6'b101010); end
    cyc();
    #2;
    checks++;
    if ({slv.r_ready, lsu.r_valid} !== 2'b00) begin errors++; $display("FAIL err_idle: got %b expected %b", {slv.r_ready, lsu.r_valid}, 2'b00); end
    cyc();
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_write_w_first();
    test_write_preempts_read();
    test_reset_mid_read();
    test_error_passthrough();
    cyc();
    checks++;
    if (exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_b.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected %0d", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_b.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
